// File: rtl/mux_arb_4to1_n.sv
// Registered 4:1 n-bit mux with per-source valid/ready handshakes and a
// single-entry output register. MODE 0 steers the channel chosen by sel;
// MODE 1 round-robin arbitrates among the four sources (sel is ignored).
module mux_arb_4to1_n #(
    parameter int n    = 8,
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] src0,
    input  logic [n-1:0] src1,
    input  logic [n-1:0] src2,
    input  logic [n-1:0] src3,
    input  logic [3:0]   vld,
    output logic [3:0]   rdy,
    input  logic [1:0]   sel,
    output logic [n-1:0] z,
    output logic         z_vld,
    input  logic         z_rdy,
    output logic [1:0]   grant
);

    logic         free;
    logic         request;
    logic         load;
    logic [1:0]   c;
    logic [1:0]   idx;
    logic [1:0]   last;
    logic [n-1:0] src_c;

    // Candidate channel: sel in MODE 0, first valid after 'last' in MODE 1.
    always_comb begin
        c       = '0;
        idx     = '0;
        request = 1'b0;
        if (MODE == 0) begin
            c       = sel;
            request = vld[sel];
        end else begin
            for (int unsigned k = 1; k <= 4; k++) begin
                idx = last + 2'(k);
                if (!request && vld[idx]) begin
                    c       = idx;
                    request = 1'b1;
                end
            end
        end
    end

    // Register is free when empty or being drained; reset blocks any accept.
    always_comb begin
        free = !z_vld | z_rdy;
        load = free & request & !reset;
        rdy  = '0;
        if (load) begin
            rdy[c] = 1'b1;
        end
    end

    // Data selection for the candidate channel.
    always_comb begin
        case (c)
            2'd0:    src_c = src0;
            2'd1:    src_c = src1;
            2'd2:    src_c = src2;
            default: src_c = src3;
        endcase
    end

    // Output register, grant index and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            z     <= '0;
            z_vld <= 1'b0;
            grant <= '0;
            last  <= 2'd3;
        end else if (free) begin
            z_vld <= load;
            if (load) begin
                z     <= src_c;
                grant <= c;
                if (MODE == 1) begin
                    last <= c;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_4to1_n.sv
// Scoreboard bench for mux_arb_4to1_n: one instance per mode, expected
// {grant, z} words queued at accept time, popped by monitors on transfer.
module tb_mux_arb_4to1_n;

    logic       clk;
    logic       reset;
    logic [7:0] src0, src1, src2, src3;
    logic [1:0] sel;
    logic [3:0] vld0, vld1;
    logic [3:0] rdy0, rdy1;
    logic [7:0] z0, z1;
    logic       z_vld0, z_vld1;
    logic       z_rdy0, z_rdy1;
    logic [1:0] grant0, grant1;

    int checks   = 0;
    int failures = 0;

    logic [9:0] q0[$];
    logic [9:0] q1[$];

    mux_arb_4to1_n #(.n(8), .MODE(0)) dut0 (
        .clk(clk), .reset(reset),
        .src0(src0), .src1(src1), .src2(src2), .src3(src3),
        .vld(vld0), .rdy(rdy0), .sel(sel),
        .z(z0), .z_vld(z_vld0), .z_rdy(z_rdy0), .grant(grant0)
    );

    mux_arb_4to1_n #(.n(8), .MODE(1)) dut1 (
        .clk(clk), .reset(reset),
        .src0(src0), .src1(src1), .src2(src2), .src3(src3),
        .vld(vld1), .rdy(rdy1), .sel(sel),
        .z(z1), .z_vld(z_vld1), .z_rdy(z_rdy1), .grant(grant1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: pop and compare whenever a word transfers to the consumer.
    always @(negedge clk) begin
        if (z_vld0 === 1'b1 && z_rdy0 === 1'b1) begin
            if (q0.size() == 0) begin
                chk("mon0_unexpected", {22'd0, grant0, z0}, 32'hFFFF_FFFF);
            end else begin
                chk("mon0_word", {22'd0, grant0, z0}, {22'd0, q0.pop_front()});
            end
        end
        if (z_vld1 === 1'b1 && z_rdy1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("mon1_unexpected", {22'd0, grant1, z1}, 32'hFFFF_FFFF);
            end else begin
                chk("mon1_word", {22'd0, grant1, z1}, {22'd0, q1.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] er;
        logic [1:0] g;
        logic [7:0] d;

        reset = 1'b1;
        src0 = 8'h11; src1 = 8'h22; src2 = 8'h33; src3 = 8'h44;
        sel = 2'd0;
        vld0 = 4'b0000; vld1 = 4'b0000;
        z_rdy0 = 1'b1;  z_rdy1 = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("rst0_z", {24'd0, z0}, 32'h0);
        chk("rst0_zvld", {31'd0, z_vld0}, 32'h0);
        chk("rst0_grant", {30'd0, grant0}, 32'h0);
        chk("rst0_rdy", {28'd0, rdy0}, 32'h0);
        chk("rst1_zvld", {31'd0, z_vld1}, 32'h0);
        step();
        reset = 1'b0;

        // MODE 0: sel steps 0..3 with all sources valid
        vld0 = 4'b1111;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            @(negedge clk);
            er = 4'b0001 << s;
            chk("m0_seq_rdy", {28'd0, rdy0}, {28'd0, er});
            if (s > 0) chk("m0_seq_zvld", {31'd0, z_vld0}, 32'h1);
            d = 8'h11 * 8'(s + 1);
            q0.push_back({2'(s), d});
            step();
        end

        // MODE 0 backpressure
        sel = 2'd1; src1 = 8'hA5;
        @(negedge clk);
        chk("m0_bp_load_rdy", {28'd0, rdy0}, 32'b0010);
        q0.push_back({2'd1, 8'hA5});
        step();
        z_rdy0 = 1'b0; src1 = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("m0_bp_rdy", {28'd0, rdy0}, 32'h0);
            chk("m0_bp_z", {24'd0, z0}, 32'hA5);
            chk("m0_bp_grant", {30'd0, grant0}, 32'h1);
            chk("m0_bp_zvld", {31'd0, z_vld0}, 32'h1);
            step();
        end
        z_rdy0 = 1'b1;
        @(negedge clk);
        chk("m0_bp_release_rdy", {28'd0, rdy0}, 32'b0010);
        q0.push_back({2'd1, 8'h5A});
        step();

        // Empty and drain
        vld0 = 4'b0000;
        @(negedge clk);
        chk("m0_nobubble_zvld", {31'd0, z_vld0}, 32'h1);
        chk("m0_drain_rdy", {28'd0, rdy0}, 32'h0);
        step();
        @(negedge clk);
        chk("m0_drain_zvld", {31'd0, z_vld0}, 32'h0);
        chk("m0_drain_zhold", {24'd0, z0}, 32'h5A);
        chk("m0_drain_rdy2", {28'd0, rdy0}, 32'h0);
        step();

        // vld[sel]=0 with other requests: no load
        sel = 2'd2; vld0 = 4'b1011;
        @(negedge clk);
        chk("m0_nosel_rdy", {28'd0, rdy0}, 32'h0);
        step();
        @(negedge clk);
        chk("m0_nosel_zvld", {31'd0, z_vld0}, 32'h0);
        step();

        // Reset mid-operation while holding 0x33
        vld0 = 4'b0100;
        @(negedge clk);
        chk("m0_pre_rst_rdy", {28'd0, rdy0}, 32'b0100);
        q0.push_back({2'd2, 8'h33});
        step();
        z_rdy0 = 1'b0; vld0 = 4'b1111;
        @(negedge clk);
        chk("m0_hold33_z", {24'd0, z0}, 32'h33);
        chk("m0_hold33_zvld", {31'd0, z_vld0}, 32'h1);
        step();
        reset = 1'b1;
        q0.delete();
        @(negedge clk);
        chk("m0_rst_rdy", {28'd0, rdy0}, 32'h0);
        step();
        @(negedge clk);
        chk("m0_rst_z", {24'd0, z0}, 32'h0);
        chk("m0_rst_zvld", {31'd0, z_vld0}, 32'h0);
        chk("m0_rst_grant", {30'd0, grant0}, 32'h0);
        chk("m0_rst_rdy2", {28'd0, rdy0}, 32'h0);
        step();
        reset = 1'b0; z_rdy0 = 1'b1; sel = 2'd0;
        @(negedge clk);
        chk("m0_post_rst_rdy", {28'd0, rdy0}, 32'b0001);
        q0.push_back({2'd0, 8'h11});
        step();
        vld0 = 4'b0000;
        @(negedge clk);
        step();
        src1 = 8'h22;

        // MODE 1: fresh reset, round-robin with all requesting
        reset = 1'b1;
        step();
        reset = 1'b0;
        vld1 = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            sel = 2'($urandom_range(0, 3));
            g = 2'(k % 4);
            @(negedge clk);
            er = 4'b0001 << g;
            chk("m1_rr_rdy", {28'd0, rdy1}, {28'd0, er});
            d = 8'h11 * 8'(g + 1);
            q1.push_back({g, d});
            step();
        end

        // Sparse requests: bring last to 0, then 1001 -> 3, 0; then 0100 -> 2
        vld1 = 4'b0001;
        @(negedge clk);
        chk("m1_sp_rdy0", {28'd0, rdy1}, 32'b0001);
        q1.push_back({2'd0, 8'h11});
        step();
        vld1 = 4'b1001;
        @(negedge clk);
        chk("m1_sp_rdy3", {28'd0, rdy1}, 32'b1000);
        q1.push_back({2'd3, 8'h44});
        step();
        @(negedge clk);
        chk("m1_sp_rdy0b", {28'd0, rdy1}, 32'b0001);
        q1.push_back({2'd0, 8'h11});
        step();
        vld1 = 4'b0100;
        @(negedge clk);
        chk("m1_sp_rdy2", {28'd0, rdy1}, 32'b0100);
        q1.push_back({2'd2, 8'h33});
        step();

        // MODE 1 backpressure: pointer must not advance while stalled
        z_rdy1 = 1'b0; vld1 = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("m1_bp_rdy", {28'd0, rdy1}, 32'h0);
            chk("m1_bp_z", {24'd0, z1}, 32'h33);
            chk("m1_bp_grant", {30'd0, grant1}, 32'h2);
            step();
        end
        z_rdy1 = 1'b1;
        @(negedge clk);
        chk("m1_bp_release_rdy", {28'd0, rdy1}, 32'b1000);
        q1.push_back({2'd3, 8'h44});
        step();

        // Reset mid-operation in MODE 1
        z_rdy1 = 1'b0;
        @(negedge clk);
        chk("m1_hold_rdy", {28'd0, rdy1}, 32'h0);
        chk("m1_hold_z", {24'd0, z1}, 32'h44);
        step();
        reset = 1'b1;
        q1.delete();
        @(negedge clk);
        chk("m1_rst_rdy", {28'd0, rdy1}, 32'h0);
        step();
        @(negedge clk);
        chk("m1_rst_z", {24'd0, z1}, 32'h0);
        chk("m1_rst_zvld", {31'd0, z_vld1}, 32'h0);
        chk("m1_rst_grant", {30'd0, grant1}, 32'h0);
        step();
        reset = 1'b0; z_rdy1 = 1'b1;
        @(negedge clk);
        chk("m1_post_rst_rdy", {28'd0, rdy1}, 32'b0001);
        q1.push_back({2'd0, 8'h11});
        step();
        vld1 = 4'b0000;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("m1_final_zvld", {31'd0, z_vld1}, 32'h0);
        chk("q0_empty", q0.size(), 32'h0);
        chk("q1_empty", q1.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_arb_4to1_n.md
Name: mux_arb_4to1_n

Overview:
Registered 4-input, n-bit multiplexer with per-source valid/ready handshakes and a single-entry output register. It generalises the plain combinational 4:1 select. It supports two modes:
- explicit select, for datapath steering under control-unit command;
- round-robin arbitration, for sharing one sink (e.g. a writeback or memory port) among four requesters.

It sits between producer stages and a single downstream consumer.

Parameters:
- n, 8, data width of each source and of the output.
- MODE, 0, 0 = sel-driven select; 1 = round-robin arbitration (sel ignored).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- src0  input  n  source 0 data.
- src1  input  n  source 1 data.
- src2  input  n  source 2 data.
- src3  input  n  source 3 data.
- vld  input  4  vld[i] = src i holds a valid word.
- rdy  output  4  rdy[i] = src i word is accepted this cycle (one-hot or zero).
- sel  input  2  channel select; MODE 0 only.
- z  output  n  registered output data.
- z_vld  output  1  z holds a valid word.
- z_rdy  input  1  consumer accepts z this cycle.
- grant  output  2  index of the channel that supplied the current z.

Behaviour:
- Reset: on any clk edge with reset=1:
  - z=0, z_vld=0, grant=0;
  - round-robin pointer last=3, so channel 0 has highest priority first;
  - reset overrides any load or transfer in the same cycle;
  - a held word is discarded.
- Register-free condition: free = !z_vld | z_rdy. This is a combinational pass-through of z_rdy, so the block is full-throughput.
- Candidate channel c, MODE 0: c = sel; a request exists iff vld[sel]=1.
- Candidate channel c, MODE 1: c is the first i with vld[i]=1, scanning (last+1), (last+2), (last+3), (last+4) mod 4; no request if vld=0.
- Load condition: load = free & request. When load=1:
  - rdy[c]=1 combinationally; all other rdy bits are 0;
  - at the clock edge: z<=src_c, grant<=c, z_vld<=1;
  - MODE 1 only: last<=c.
- Idle cases:
  - free & !request: rdy=0; at the edge z_vld<=0 and z, grant hold their values.
  - !free (z_vld=1, z_rdy=0): rdy=0; z, grant, z_vld and last all hold.
- Latency: a word accepted in cycle t appears on z with z_vld=1 from cycle t+1.
- Simultaneous drain and load: z_vld=1, z_rdy=1 and a request in the same cycle:
  - the old word transfers;
  - the new word loads;
  - z_vld stays 1 with no bubble.
- Stability: while z_vld=1 and z_rdy=0, z and grant must not change.
- Combinational path from vld to rdy is permitted. Sources must not make vld depend on rdy.
- Fairness, MODE 1: with all four vld held high and z_rdy=1, grants cycle 0,1,2,3,0,... with no channel starved.
- MODE 0 with vld[sel]=0: no load, even if other vld bits are set.
- Wrap-around: the pointer is 2-bit and wraps naturally (3 -> 0).
- Outputs are never X after reset.

Test Plan:
1. Reset, MODE 0, n=8: src0..3=0x11,0x22,0x33,0x44; vld=4'b1111, z_rdy=1; sel steps 0,1,2,3 on consecutive cycles → one cycle later, z=0x11,0x22,0x33,0x44 with grant=0..3, z_vld=1 throughout, rdy one-hot matching sel.
2. Backpressure, MODE 0: load 0xA5 from src1, then z_rdy=0 for 3 cycles while src1 changes to 0x5A → rdy=0, z stays 0xA5 and grant=1 for all 3 cycles; z_rdy=1 → 0x5A loads next edge, no bubble.
3. Round-robin, MODE 1: vld=4'b1111 and z_rdy=1 for 6 cycles after reset → grant sequence 0,1,2,3,0,1; sel toggled randomly has no effect.
4. Sparse requests, MODE 1: last=0 with vld=4'b1001 → grant=3, then grant=0; with vld=4'b0100 only → grant=2 and rdy=4'b0100.
5. Empty and drain: vld=0, z_rdy=1 after a valid word → z_vld falls to 0 next cycle, z holds its last value, rdy=0.
6. Reset mid-operation: z_vld=1, z_rdy=0, holding 0x33; assert reset with vld=4'b1111 → next edge z=0, z_vld=0, grant=0, rdy=0; first grant after reset release is channel 0.
